// File: rtl/fft_bitrev_reorder.sv
// -----------------------------------------------------------------------------
// fft_bitrev_reorder
//
// Output reorder buffer for the SDF FFT pipeline. Each frame arrives as a
// contiguous stream in bit-reversed index order. It is captured into one half
// of a ping-pong memory at bit-reversed addresses, then replayed in natural
// order X[0]..X[FFT_POINTS-1]. The writer and the reader each move one sample
// per cycle, so back-to-back frames stream through without gaps.
//
// Parameters
//   WIDTH       bit width of each real / imaginary word
//   FFT_POINTS  frame length, power of two, 4..1024
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   In_en      input sample valid; a frame is FFT_POINTS consecutive valid cycles
//   In_real    input real part (two's complement)
//   In_img     input imaginary part (two's complement)
//   Out_en     output sample valid
//   Out_real   natural-order real part (holds its value while Out_en = 0)
//   Out_img    natural-order imaginary part (holds its value while Out_en = 0)
// -----------------------------------------------------------------------------
module fft_bitrev_reorder #(
    parameter int WIDTH      = 16,
    parameter int FFT_POINTS = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             In_en,
    input  logic [WIDTH-1:0] In_real,
    input  logic [WIDTH-1:0] In_img,
    output logic             Out_en,
    output logic [WIDTH-1:0] Out_real,
    output logic [WIDTH-1:0] Out_img
);

    localparam int N = $clog2(FFT_POINTS);
    localparam logic [N-1:0] LAST = N'(FFT_POINTS - 1);

    typedef enum logic {
        ST_IDLE,
        ST_READ
    } rd_state_t;

    function automatic logic [N-1:0] bitrev(input logic [N-1:0] a);
        logic [N-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < N; i++) begin
            r[i] = a[N-1-i];
        end
        return r;
    endfunction

    // Both banks share one array; the MSB of the address selects the bank.
    logic [2*WIDTH-1:0] mem [2*FFT_POINTS];

    // ---------------------------------------------------------------- writer
    logic [N-1:0] wr_count;
    logic         wr_bank;
    logic         wr_done;

    assign wr_done = In_en && (wr_count == LAST);

    // A partial frame simply stops counting; the bank is reused by the next
    // frame because neither wr_bank nor the full flag moved.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_count <= '0;
            wr_bank  <= 1'b0;
        end else if (In_en) begin
            wr_count <= wr_count + 1'b1;
            if (wr_done) begin
                wr_bank <= ~wr_bank;
            end
        end else begin
            wr_count <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (In_en) begin
            mem[{wr_bank, bitrev(wr_count)}] <= {In_real, In_img};
        end
    end

    // ------------------------------------------------------------ bank flags
    logic [1:0] full;
    logic [1:0] full_next;
    logic       rd_last;
    logic       rd_bank;

    // Reader clear and writer set are merged so both land on the same edge;
    // they always target different banks.
    always_comb begin
        full_next = full;
        if (rd_last) begin
            full_next[rd_bank] = 1'b0;
        end
        if (wr_done) begin
            full_next[wr_bank] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full <= '0;
        end else begin
            full <= full_next;
        end
    end

    // ---------------------------------------------------------------- reader
    rd_state_t    state;
    rd_state_t    state_next;
    logic [N-1:0] rd_count;
    logic [N-1:0] rd_count_next;
    logic         rd_bank_next;
    logic         rd_issue;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            rd_count <= '0;
            rd_bank  <= 1'b0;
        end else begin
            state    <= state_next;
            rd_count <= rd_count_next;
            rd_bank  <= rd_bank_next;
        end
    end

    always_comb begin
        state_next    = state;
        rd_count_next = rd_count;
        rd_bank_next  = rd_bank;
        rd_issue      = 1'b0;
        rd_last       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (full[rd_bank]) begin
                    state_next    = ST_READ;
                    rd_count_next = '0;
                end
            end
            ST_READ: begin
                rd_issue      = 1'b1;
                rd_count_next = rd_count + 1'b1;
                if (rd_count == LAST) begin
                    rd_last      = 1'b1;
                    rd_bank_next = ~rd_bank;
                    // Stay in READ (count wraps to 0) when the other bank is
                    // ready, giving a gapless output between frames.
                    if (!full[~rd_bank]) begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------- output register
    // The synchronous memory read doubles as the output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Out_en   <= 1'b0;
            Out_real <= '0;
            Out_img  <= '0;
        end else begin
            Out_en <= rd_issue;
            if (rd_issue) begin
                {Out_real, Out_img} <= mem[{rd_bank, rd_count}];
            end
        end
    end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// -----------------------------------------------------------------------------
// tb_fft_bitrev_reorder
//
// Directed bench for fft_bitrev_reorder. A 64-point instance covers single,
// back-to-back, partial, gapped and reset-interrupted frames; a 16-point
// instance covers the small-frame build. Outputs are sampled on the falling
// edge into queues and compared against hand-derived values.
// -----------------------------------------------------------------------------
module tb_fft_bitrev_reorder;

    logic        clk;
    logic        reset;

    logic        in_en;
    logic [15:0] in_real;
    logic [15:0] in_img;
    logic        out_en;
    logic [15:0] out_real;
    logic [15:0] out_img;

    logic        in_en16;
    logic [15:0] in_real16;
    logic [15:0] in_img16;
    logic        out_en16;
    logic [15:0] out_real16;
    logic [15:0] out_img16;

    int n_tests;
    int n_fail;
    int cyc;
    int last_e;

    int q_real[$];
    int q_img[$];
    int q_cyc[$];
    int q16_real[$];

    fft_bitrev_reorder #(.WIDTH(16), .FFT_POINTS(64)) dut (
        .clk      (clk),
        .reset    (reset),
        .In_en    (in_en),
        .In_real  (in_real),
        .In_img   (in_img),
        .Out_en   (out_en),
        .Out_real (out_real),
        .Out_img  (out_img)
    );

    fft_bitrev_reorder #(.WIDTH(16), .FFT_POINTS(16)) dut16 (
        .clk      (clk),
        .reset    (reset),
        .In_en    (in_en16),
        .In_real  (in_real16),
        .In_img   (in_img16),
        .Out_en   (out_en16),
        .Out_real (out_real16),
        .Out_img  (out_img16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (out_en) begin
            q_real.push_back(int'(out_real));
            q_img.push_back(int'(out_img));
            q_cyc.push_back(cyc);
        end
        if (out_en16) begin
            q16_real.push_back(int'(out_real16));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int w16(input int v);
        return v & 32'hFFFF;
    endfunction

    function automatic int bitrev6(input int v);
        logic [5:0] a;
        logic [5:0] r;
        a = 6'(v);
        for (int b = 0; b < 6; b++) r[b] = a[5-b];
        return int'(r);
    endfunction

    task automatic clear_q();
        q_real.delete();
        q_img.delete();
        q_cyc.delete();
        q16_real.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_en   = 1'b0;
            in_en16 = 1'b0;
        end
    endtask

    // Sample i of the frame carries base+i on real and -(base+i) on img.
    task automatic send_frame(input int base, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            @(negedge clk);
            in_en   = 1'b1;
            in_real = 16'(base + i);
            in_img  = 16'(-(base + i));
            last_e  = cyc + 1;
        end
    endtask

    initial begin
        int e;
        int found;
        n_tests  = 0;
        n_fail   = 0;
        cyc      = 0;
        reset    = 1'b1;
        in_en    = 1'b0;
        in_real  = '0;
        in_img   = '0;
        in_en16  = 1'b0;
        in_real16 = '0;
        in_img16 = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_out_en", int'(out_en), 0);
        check("rst_out_real", int'(out_real), 0);
        check("rst_out_img", int'(out_img), 0);
        check("rst_out_en16", int'(out_en16), 0);
        reset = 1'b0;
        idle(2);

        // Single frame: real=i, img=-i
        clear_q();
        send_frame(0, 64);
        e = last_e;
        idle(80);
        check("single_count", q_real.size(), 64);
        if (q_real.size() == 64) begin
            check("single_first_cyc", q_cyc[0], e + 2);
            check("single_span", q_cyc[63] - q_cyc[0], 63);
            check("single_r0", q_real[0], 0);
            check("single_r1", q_real[1], 32);
            check("single_r2", q_real[2], 16);
            check("single_r3", q_real[3], 48);
            check("single_r63", q_real[63], 63);
            check("single_i1", q_img[1], w16(-32));
            check("single_i2", q_img[2], w16(-16));
            check("single_i3", q_img[3], w16(-48));
            check("single_i63", q_img[63], w16(-63));
            for (int k = 0; k < 64; k++) begin
                check($sformatf("single_all_r%0d", k), q_real[k], bitrev6(k));
            end
        end

        // Two back-to-back frames
        clear_q();
        send_frame(0, 64);
        send_frame(100, 64);
        idle(150);
        check("b2b_count", q_real.size(), 128);
        if (q_real.size() == 128) begin
            check("b2b_span", q_cyc[127] - q_cyc[0], 127);
            check("b2b_r1", q_real[1], 32);
            check("b2b_r64", q_real[64], 100);
            check("b2b_r65", q_real[65], 132);
            check("b2b_r127", q_real[127], 163);
        end

        // Partial frame then full frame
        clear_q();
        send_frame(500, 20);
        idle(5);
        send_frame(200, 64);
        idle(80);
        check("partial_count", q_real.size(), 64);
        if (q_real.size() == 64) begin
            for (int k = 0; k < 64; k++) begin
                check($sformatf("partial_r%0d", k), q_real[k], 200 + bitrev6(k));
            end
        end

        // Frames separated by idle cycles
        clear_q();
        send_frame(300, 64);
        idle(10);
        send_frame(400, 64);
        idle(150);
        check("gap_count", q_real.size(), 128);
        if (q_real.size() == 128) begin
            check("gap_r0", q_real[0], 300);
            check("gap_r1", q_real[1], 332);
            check("gap_r64", q_real[64], 400);
            check("gap_r65", q_real[65], 432);
            check("gap_hole", int'((q_cyc[64] - q_cyc[63]) > 1), 1);
            check("gap_span1", q_cyc[63] - q_cyc[0], 63);
            check("gap_span2", q_cyc[127] - q_cyc[64], 63);
        end

        // Reset 30 cycles into readout
        clear_q();
        send_frame(600, 64);
        found = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            in_en = 1'b0;
            #1;
            if (q_real.size() >= 30) begin
                found = 1;
                break;
            end
        end
        check("mid_reached30", found, 1);
        check("mid_pre_en", int'(out_en), 1);
        reset = 1'b1;
        #1;
        check("mid_rst_en", int'(out_en), 0);
        check("mid_rst_real", int'(out_real), 0);
        check("mid_rst_img", int'(out_img), 0);
        idle(2);
        reset = 1'b0;
        clear_q();
        idle(100);
        check("mid_no_output", q_real.size(), 0);
        send_frame(700, 64);
        e = last_e;
        idle(80);
        check("mid_new_count", q_real.size(), 64);
        if (q_real.size() == 64) begin
            check("mid_new_first_cyc", q_cyc[0], e + 2);
            check("mid_new_r0", q_real[0], 700);
            check("mid_new_r1", q_real[1], 732);
        end

        // 16-point build
        clear_q();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            in_en16   = 1'b1;
            in_real16 = 16'(i);
            in_img16  = '0;
        end
        idle(30);
        check("p16_count", q16_real.size(), 16);
        if (q16_real.size() == 16) begin
            check("p16_r0", q16_real[0], 0);
            check("p16_r1", q16_real[1], 8);
            check("p16_r2", q16_real[2], 4);
            check("p16_r3", q16_real[3], 12);
            check("p16_r15", q16_real[15], 15);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
